fb_pixel_writer: RTL and testbench

//  Receiving end of the pixel-plot interface (x, y, colour, plot) driven by our sprite/animation datapaths.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_pixel_writer_if.sv | 30 +++
 rtl/pix_fifo.sv | 44 ++++
 rtl/fb_pixel_writer.sv | 134 +++++++++++++
 tb/tb_fb_pixel_writer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, clear-controller state encodings and the (x,y) -> linear address mapper.
// No logic of its own; imported by the interface, the FIFO user and the top.
package fb_pkg;
    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 17;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int N_PIX    = H_RES * V_RES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pix_req_t;

    // Constant multiplier folds to (y<<8)+(y<<6)+x for H_RES=320; in-range inputs cannot overflow.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel-plot request, clear control and framebuffer write-port signals as one bundle.
// slave = the pixel writer, master = the plot source / RAM side driving it.
interface fb_pixel_writer_if;
    import fb_pkg::*;

    logic [X_W-1:0]      in_x;
    logic [Y_W-1:0]      in_y;
    logic [COLOUR_W-1:0] in_colour;
    logic                in_plot;
    logic                in_ready;
    logic                clear_req;
    logic [COLOUR_W-1:0] clear_colour;
    logic                clear_busy;
    logic                clear_done;
    logic                rd_busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic [COLOUR_W-1:0] mem_wdata;
    logic                mem_we;
    logic [7:0]          drop_cnt;

    modport slave (
        input  in_x, in_y, in_colour, in_plot, clear_req, clear_colour, rd_busy,
        output in_ready, clear_busy, clear_done, mem_addr, mem_wdata, mem_we, drop_cnt
    );

    modport master (
        output in_x, in_y, in_colour, in_plot, clear_req, clear_colour, rd_busy,
        input  in_ready, clear_busy, clear_done, mem_addr, mem_wdata, mem_we, drop_cnt
    );
endinterface

// File: rtl/pix_fifo.sv
// Synchronous FIFO for plot requests; data visible at the head one edge after push.
// Caller must not push when full or pop when empty; a same-edge pop does not make room for a push.
module pix_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W:0]   wr_ptr_q;
    logic [IDX_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/fb_pixel_writer.sv
// Bounds-checks plot requests, buffers them and writes them to the framebuffer when scanout is idle; also clears the screen.
// Write appears one edge after acceptance at the earliest; rd_busy stalls writes, a full FIFO or active clear drops in_ready.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    fb_pixel_writer_if.slave   bus
);
    state_t              state_q;
    logic [COLOUR_W-1:0] clr_colour_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                clear_busy_q;
    logic                clear_done_q;
    logic [7:0]          drop_cnt_q;

    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [COLOUR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                mem_we_q,    mem_we_d;

    logic     in_ready;
    logic     accept;
    logic     in_range;
    logic     push;
    logic     pop;
    logic     clr_wr;
    logic     fifo_full;
    logic     fifo_empty;
    pix_req_t push_req;
    pix_req_t head_req;

    assign in_ready = (state_q == ST_IDLE) && !fifo_full;
    assign accept   = bus.in_plot && in_ready;
    assign in_range = (bus.in_x < X_W'(H_RES)) && (bus.in_y < Y_W'(V_RES));
    assign push     = accept && in_range;
    assign pop      = !fifo_empty && !bus.rd_busy;
    // The FIFO is always empty in CLEAR, so plot and clear writes never compete.
    assign clr_wr   = (state_q == ST_CLEAR) && !bus.rd_busy;

    assign push_req.addr   = xy_to_addr(bus.in_x, bus.in_y);
    assign push_req.colour = bus.in_colour;

    pix_fifo #(
        .WIDTH ($bits(pix_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_req),
        .pop_i   (pop),
        .rdata_o (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            clr_colour_q <= '0;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        clr_colour_q <= bus.clear_colour;
                        clear_busy_q <= 1'b1;
                        state_q      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        clr_cnt_q <= '0;
                        state_q   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (!bus.rd_busy) begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                        if (clr_cnt_q == ADDR_W'(N_PIX - 1)) begin
                            clear_busy_q <= 1'b0;
                            clear_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (pop) begin
            mem_addr_d  = head_req.addr;
            mem_wdata_d = head_req.colour;
            mem_we_d    = 1'b1;
        end else if (clr_wr) begin
            mem_addr_d  = clr_cnt_q;
            mem_wdata_d = clr_colour_q;
            mem_we_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if (accept && !in_range && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.clear_busy = clear_busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: reset, single plot, back-pressure, bounds, saturation, clear, reset mid-clear.
module tb_fb_pixel_writer;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    fb_pixel_writer_if bus ();

    fb_pixel_writer #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int pa [3] = '{3210, 6420, 9630};
    int pc [3] = '{1, 4, 6};

    initial begin
        int idx, wr_seen, nw, last_addr;
        int w, bad_ord, rdy_bad, ndone, exp_a, exp_c;
        bit found;

        reset            = 1'b0;
        bus.in_x         = '0;
        bus.in_y         = '0;
        bus.in_colour    = '0;
        bus.in_plot      = 1'b0;
        bus.clear_req    = 1'b0;
        bus.clear_colour = '0;
        bus.rd_busy      = 1'b0;
        tick();
        tick();
        chk("rst_we",    bus.mem_we, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_busy",  bus.clear_busy, 0);
        chk("rst_done",  bus.clear_done, 0);
        chk("rst_drop",  bus.drop_cnt, 0);
        chk("rst_rdy",   bus.in_ready, 1);
        reset = 1'b1;
        tick();

        // single plot (5,2) -> 2*320+5 = 645
        bus.in_x = 9'd5; bus.in_y = 8'd2; bus.in_colour = 3'b101; bus.in_plot = 1'b1;
        #1 chk("single_rdy", bus.in_ready, 1);
        tick();
        bus.in_plot = 1'b0;
        chk("single_lat", bus.mem_we, 0);
        tick();
        chk("single_we",    bus.mem_we, 1);
        chk("single_addr",  bus.mem_addr, 645);
        chk("single_wdata", bus.mem_wdata, 3'b101);
        tick();
        chk("single_once", bus.mem_we, 0);

        // back-pressure: plot k is (10+k, 1) -> 330+k
        bus.rd_busy = 1'b1;
        idx = 0; wr_seen = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_x = 9'(10 + idx); bus.in_y = 8'd1; bus.in_colour = 3'(idx); bus.in_plot = 1'b1;
            #1 if (bus.in_ready) idx++;
            tick();
            if (bus.mem_we) wr_seen++;
        end
        bus.in_plot = 1'b0;
        #1;
        chk("bp_accepted", idx, 4);
        chk("bp_rdy_full", bus.in_ready, 0);
        chk("bp_no_write", wr_seen, 0);
        bus.rd_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_we",    bus.mem_we, 1);
            chk("bp_addr",  bus.mem_addr, 330 + k);
            chk("bp_wdata", bus.mem_wdata, k);
        end
        tick();
        chk("bp_idle", bus.mem_we, 0);
        chk("bp_rdy",  bus.in_ready, 1);
        bus.in_x = 9'd14; bus.in_colour = 3'd4; bus.in_plot = 1'b1;
        tick();
        bus.in_x = 9'd15; bus.in_colour = 3'd5;
        tick();
        bus.in_plot = 1'b0;
        chk("bp_rest4_addr",  bus.mem_addr, 334);
        chk("bp_rest4_wdata", bus.mem_wdata, 4);
        tick();
        chk("bp_rest5_we",    bus.mem_we, 1);
        chk("bp_rest5_addr",  bus.mem_addr, 335);
        chk("bp_rest5_wdata", bus.mem_wdata, 5);

        // bounds
        bus.in_colour = 3'd7; bus.in_plot = 1'b1;
        bus.in_x = 9'd320; bus.in_y = 8'd0;   tick();
        bus.in_x = 9'd0;   bus.in_y = 8'd240; tick();
        bus.in_x = 9'd319; bus.in_y = 8'd239; tick();
        bus.in_plot = 1'b0;
        nw = 0; last_addr = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.mem_we) begin nw++; last_addr = int'(bus.mem_addr); end
        end
        chk("bnd_writes", nw, 1);
        chk("bnd_addr",   last_addr, 76799);
        chk("bnd_drop",   bus.drop_cnt, 2);

        // saturation
        bus.in_x = 9'd400; bus.in_y = 8'd0; bus.in_plot = 1'b1;
        nw = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.mem_we) nw++;
            if (i == 99) chk("sat_mid", bus.drop_cnt, 102);
        end
        bus.in_plot = 1'b0;
        chk("sat_drop",   bus.drop_cnt, 255);
        chk("sat_writes", nw, 0);

        // clear with three buffered plots
        bus.rd_busy = 1'b1;
        for (int p = 0; p < 3; p++) begin
            bus.in_x = 9'(10 * (p + 1)); bus.in_y = 8'(10 * (p + 1));
            bus.in_colour = 3'(pc[p]); bus.in_plot = 1'b1;
            tick();
        end
        bus.in_plot = 1'b0;
        bus.rd_busy = 1'b0;
        bus.clear_req = 1'b1; bus.clear_colour = 3'b010;
        tick();
        bus.clear_req = 1'b0;
        chk("clr_busy", bus.clear_busy, 1);
        w = 0; bad_ord = 0; rdy_bad = 0; ndone = 0;
        for (int cyc = 0; cyc < 80000; cyc++) begin
            if (bus.mem_we) begin
                exp_a = (w < 3) ? pa[w] : w - 3;
                exp_c = (w < 3) ? pc[w] : 2;
                if (int'(bus.mem_addr) != exp_a || int'(bus.mem_wdata) != exp_c) bad_ord++;
                w++;
            end
            if (bus.in_ready) rdy_bad++;
            if (bus.clear_done) begin ndone++; break; end
            tick();
        end
        chk("clr_done_seen", ndone, 1);
        chk("clr_writes",    w, 76803);
        chk("clr_order",     bad_ord, 0);
        chk("clr_rdy_low",   rdy_bad, 0);
        chk("clr_busy_end",  bus.clear_busy, 0);
        tick();
        chk("clr_done_pulse", bus.clear_done, 0);
        chk("clr_rdy_back",   bus.in_ready, 1);
        chk("clr_we_stop",    bus.mem_we, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.clear_done) ndone++;
        end
        chk("clr_done_once", ndone, 1);

        // reset mid-clear at address 1000
        bus.clear_req = 1'b1; bus.clear_colour = 3'b101;
        tick();
        bus.clear_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus.mem_we && bus.mem_addr == 17'd1000) begin found = 1'b1; break; end
            tick();
        end
        chk("rmc_reach", found, 1);
        reset = 1'b0;
        tick();
        chk("rmc_we",   bus.mem_we, 0);
        chk("rmc_busy", bus.clear_busy, 0);
        chk("rmc_drop", bus.drop_cnt, 0);
        chk("rmc_addr", bus.mem_addr, 0);
        reset = 1'b1;
        tick();
        chk("rmc_rdy", bus.in_ready, 1);
        bus.in_x = 9'd7; bus.in_y = 8'd3; bus.in_colour = 3'd6; bus.in_plot = 1'b1;
        tick();
        bus.in_plot = 1'b0;
        tick();
        chk("rmc_plot_we",    bus.mem_we, 1);
        chk("rmc_plot_addr",  bus.mem_addr, 967);
        chk("rmc_plot_wdata", bus.mem_wdata, 6);
        tick();
        chk("rmc_plot_once", bus.mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
